pte_wb_slave: RTL and testbench
===============================

PTE_WB_SLAVE -- requirements
Module: pte_wb_slave

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: idle cycles between request acceptance and response, legal range 0..15.
REQ-002 SHALL have parameter IDX_W, default 6: the table holds 2^IDX_W entries, indexed by vpn[IDX_W-1:0].
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have wb_cyc_i, wb_stb_i, wb_we_i, each input, 1: Wishbone classic cycle, strobe and write-enable.
REQ-006 SHALL have wb_adr_i input 32, wb_dat_i input 32, wb_sel_i input 4, wb_cti_i input 3, wb_bte_i input 2.
REQ-007 SHALL have wb_dat_o output 32: read data.
REQ-008 SHALL have wb_ack_o, wb_err_o, wb_rty_o, each output, 1: transfer terminations.
REQ-009 SHALL have tbl_lock input 1: table busy (software update in progress); causes a retry.

Function
REQ-010 Address decode: vpn = wb_adr_i[21:2]; index = vpn[IDX_W-1:0]; stored tag = vpn[19:IDX_W].
REQ-011 Entry layout: valid bit, tag, 26-bit payload {ppn[21:0], flags[3:0]}.
REQ-012 Read data on a hit SHALL be {6'b0, payload}.
REQ-013 FSM states: IDLE, WAIT, RESP. All outputs SHALL be registered.
REQ-014 IDLE -> WAIT when wb_cyc_i & wb_stb_i, or directly -> RESP when WAIT_CYCLES=0.
  - Address, we, data, sel and cti SHALL be latched at this acceptance edge.
REQ-015 WAIT SHALL count down WAIT_CYCLES, then -> RESP.
  - If wb_cyc_i drops during WAIT: -> IDLE, no response, no table write.
REQ-016 RESP SHALL assert exactly one of ack/err/rty for exactly one cycle, then -> IDLE.
  - A request still present in the cycle after RESP SHALL be treated as new.
REQ-017 Latency: request accepted at edge k -> termination high during cycle k+1+WAIT_CYCLES.
REQ-018 Termination priority: err > rty > ack.
REQ-019 err SHALL be asserted when any of the following holds:
  - wb_adr_i[31:22] != 0;
  - wb_adr_i[1:0] != 0;
  - wb_cti_i != 3'b111;
  - wb_bte_i != 2'b00;
  - a write with wb_sel_i != 4'hf;
  - a read that misses (entry invalid or tag mismatch).
REQ-020 rty SHALL be asserted when tbl_lock is high at the RESP evaluation edge and no error applies.
REQ-021 Read hit: ack, with wb_dat_o = entry data.
REQ-022 Write (wb_dat_i[31]=1): set valid, store tag and wb_dat_i[25:0] on the RESP edge, then ack.
REQ-023 Write (wb_dat_i[31]=0): clear valid, then ack.
REQ-024 Written data SHALL be visible to a read accepted on any later edge.
REQ-025 wb_dat_o SHALL hold its last value until the next read termination.
  - Requesters may sample it one cycle after ack.
  - Error and retry terminations SHALL drive wb_dat_o = 0.
REQ-026 wb_stb_i/wb_cyc_i changes while in RESP SHALL NOT alter the current termination.

Reset
REQ-027 On rst: state=IDLE, wait counter=0, wb_ack_o=wb_err_o=wb_rty_o=0, wb_dat_o=0.
REQ-028 On rst: all valid bits SHALL clear in that same cycle. Tag and payload storage need no reset.
REQ-029 rst mid-transaction SHALL abort it: no termination, no table write. Table contents are reset only as per REQ-028.

Structure
REQ-030 A shared package SHALL hold:
  - PTE field widths (VPN 20, PPN 22, FLAGS 4, payload 26);
  - the FSM state encoding;
  - the CTI_CLASSIC (3'b111) constant.
REQ-031 A single sub-module pte_ram SHALL hold tag+payload storage: one write port, one combinational read port, 2^IDX_W deep. Valid bits SHALL stay flip-flops in pte_wb_slave.

Verification
REQ-032 Write 0x80000ABC to adr {10'b0,vpn=0x12345,2'b0}, then read the same address -> ack, wb_dat_o=0x00000ABC, ack at cycle k+3 (WAIT_CYCLES=2).
REQ-033 Read vpn=0x00045 after vpn=0x12345 was written (same index 0x05, different tag) -> err, wb_dat_o=0.
REQ-034 tbl_lock=1, read of a valid entry -> rty for one cycle; lock released and request reissued -> ack with correct data.
REQ-035 wb_adr_i=0x00400000 or wb_cti_i=3'b010 -> err, table unchanged.
REQ-036 wb_cyc_i dropped in WAIT during a write -> no termination; a later read of that vpn -> err.
REQ-037 rst asserted mid-read -> all terminations stay 0; after reset, a read of a previously written entry -> err (valid cleared).

Source files
------------

// File: rtl/pte_wb_slave_pkg.sv
// Shared definitions for the page-table-entry Wishbone slave: PTE field widths,
// FSM state encoding and bus constants.
package pte_wb_slave_pkg;

  localparam int VPN_W     = 20;
  localparam int PPN_W     = 22;
  localparam int FLAGS_W   = 4;
  localparam int PAYLOAD_W = PPN_W + FLAGS_W;

  localparam logic [2:0] CTI_CLASSIC = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/pte_wb_slave_ram.sv
// Tag + payload storage for the PTE table: one synchronous write port and one
// combinational read port.
module pte_ram #(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 14,
  parameter int DATA_W = 26
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [TAG_W-1:0]  o_rtag,
  output logic [DATA_W-1:0] o_rdata
);

  logic [TAG_W+DATA_W-1:0] r_mem [2**IDX_W];

  // NOTE: storage has no reset; entry validity lives in flip-flops in the parent.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= {i_wtag, i_wdata};
    end
  end

  assign {o_rtag, o_rdata} = r_mem[i_raddr];

endmodule

// File: rtl/pte_wb_slave.sv
// Wishbone classic slave exposing a direct-mapped PTE table: programmable
// response latency, err/rty/ack terminations and valid bits in flip-flops.
module pte_wb_slave
  import pte_wb_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int IDX_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  input  logic        tbl_lock,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int         TAG_W     = VPN_W - IDX_W;
  localparam int         ENTRIES   = 2**IDX_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t               r_state;
  logic [3:0]           r_wait_cnt;
  logic [ENTRIES-1:0]   r_valid;
  logic                 r_ack, r_err, r_rty;
  logic [31:0]          r_dat_o;

  logic [31:0]          r_adr;
  logic                 r_we;
  logic                 r_dat_valid;
  logic [PAYLOAD_W-1:0] r_dat_payload;
  logic [3:0]           r_sel;
  logic [2:0]           r_cti;
  logic [1:0]           r_bte;

  logic                 w_accept;
  logic [VPN_W-1:0]     w_vpn;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [TAG_W-1:0]     w_ram_tag;
  logic [PAYLOAD_W-1:0] w_ram_payload;
  logic                 w_hit, w_err, w_rty, w_ram_we;
  logic                 w_unused;

  assign w_accept = (r_state == S_IDLE) && wb_cyc_i && wb_stb_i;
  assign w_vpn    = r_adr[21:2];
  assign w_idx    = w_vpn[IDX_W-1:0];
  assign w_tag    = w_vpn[VPN_W-1:IDX_W];
  assign w_unused = ^wb_dat_i[30:PAYLOAD_W];

  assign w_hit = r_valid[w_idx] && (w_ram_tag == w_tag);
  assign w_err = (r_adr[31:22] != '0) || (r_adr[1:0] != 2'b00) ||
                 (r_cti != CTI_CLASSIC) || (r_bte != 2'b00) ||
                 (r_we && (r_sel != 4'hf)) || (!r_we && !w_hit);
  assign w_rty = !w_err && tbl_lock;

  // Only a successful, non-aborted write that sets valid touches the storage.
  assign w_ram_we = (r_state == S_RESP) && !rst && r_we && !w_err && !w_rty && r_dat_valid;

  pte_ram #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (PAYLOAD_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_idx),
    .i_wtag  (w_tag),
    .i_wdata (r_dat_payload),
    .i_raddr (w_idx),
    .o_rtag  (w_ram_tag),
    .o_rdata (w_ram_payload)
  );

  // Request capture is pure datapath, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_adr         <= wb_adr_i;
      r_we          <= wb_we_i;
      r_dat_valid   <= wb_dat_i[31];
      r_dat_payload <= wb_dat_i[PAYLOAD_W-1:0];
      r_sel         <= wb_sel_i;
      r_cti         <= wb_cti_i;
      r_bte         <= wb_bte_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_valid    <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rty      <= 1'b0;
      r_dat_o    <= 32'd0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rty <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            r_wait_cnt <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
          end else if (r_wait_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (w_err) begin
            r_err   <= 1'b1;
            r_dat_o <= 32'd0;
          end else if (w_rty) begin
            r_rty   <= 1'b1;
            r_dat_o <= 32'd0;
          end else begin
            r_ack <= 1'b1;
            if (r_we) begin
              r_valid[w_idx] <= r_dat_valid;
            end else begin
              r_dat_o <= {{(32-PAYLOAD_W){1'b0}}, w_ram_payload};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = r_rty;
  assign wb_dat_o = r_dat_o;

endmodule

// File: tb/tb_pte_wb_slave.sv
// Self-checking bench for pte_wb_slave: directed scenarios followed by random
// transactions scored against a table model built from the access rules.
module tb_pte_wb_slave;

  localparam int WAIT_CYCLES = 2;
  localparam int IDX_W       = 6;
  localparam int ENTRIES     = 2**IDX_W;

  logic        clk;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic        tbl_lock;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one slot per index remembering the full vpn it holds.
  bit          m_valid [ENTRIES];
  logic [19:0] m_vpn   [ENTRIES];
  logic [25:0] m_pay   [ENTRIES];
  logic [31:0] m_dat;

  pte_wb_slave #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .IDX_W       (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_cti_i (wb_cti_i),
    .wb_bte_i (wb_bte_i),
    .tbl_lock (tbl_lock),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .wb_rty_o (wb_rty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] adr_of(input logic [19:0] vpn);
    return {10'b0, vpn, 2'b00};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_dat = 32'd0;
  endtask

  // One complete bus transaction; terminations encoded as {err, rty, ack}.
  task automatic xfer(input string tag, input logic [31:0] adr, input logic we,
                      input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti,
                      input logic [1:0] bte, input logic lock);
    logic [19:0] vpn;
    int          idx;
    logic        bad_fmt, hit;
    logic [2:0]  exp_term, got_term;
    int          lat;
    vpn     = adr[21:2];
    idx     = int'(vpn) % ENTRIES;
    bad_fmt = (adr >= 32'h0040_0000) || (adr % 4 != 0) || (cti != 3'b111) ||
              (bte != 2'b00) || (we && sel != 4'hf);
    hit     = m_valid[idx] && (m_vpn[idx] == vpn);
    if (bad_fmt || (!we && !hit)) exp_term = 3'b100;
    else if (lock)                exp_term = 3'b010;
    else                          exp_term = 3'b001;

    @(negedge clk);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
    wb_cti_i = cti; wb_bte_i = bte; tbl_lock = lock;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk);
    lat = 0;
    got_term = 3'b000;
    while (lat < 16 && got_term == 3'b000) begin
      @(posedge clk); #1;
      lat++;
      got_term = {wb_err_o, wb_rty_o, wb_ack_o};
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; tbl_lock = 1'b0;
    check({tag, ":term"}, 32'(got_term), 32'(exp_term));
    check({tag, ":latency"}, 32'(lat), 32'(1 + WAIT_CYCLES));

    if (exp_term == 3'b001) begin
      if (we) begin
        if (dat[31]) begin
          m_valid[idx] = 1'b1;
          m_vpn[idx]   = vpn;
          m_pay[idx]   = dat[25:0];
        end else begin
          m_valid[idx] = 1'b0;
        end
      end else begin
        m_dat = 32'(m_pay[idx]);
      end
    end else begin
      m_dat = 32'd0;
    end

    @(posedge clk); #1;
    check({tag, ":one_cycle"}, 32'({wb_err_o, wb_rty_o, wb_ack_o}), 32'd0);
    check({tag, ":dat"}, wb_dat_o, m_dat);
  endtask

  task automatic rd(input string tag, input logic [19:0] vpn, input logic lock);
    xfer(tag, adr_of(vpn), 1'b0, 32'd0, 4'hf, 3'b111, 2'b00, lock);
  endtask

  task automatic wr(input string tag, input logic [19:0] vpn, input logic [31:0] dat);
    xfer(tag, adr_of(vpn), 1'b1, dat, 4'hf, 3'b111, 2'b00, 1'b0);
  endtask

  // Watches a window of cycles and returns the OR of all terminations seen.
  task automatic watch_terms(input int cycles, output logic [2:0] seen);
    seen = 3'b000;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      seen |= {wb_err_o, wb_rty_o, wb_ack_o};
    end
  endtask

  initial begin
    logic [2:0]  seen;
    logic [19:0] vpn;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        we, lock;

    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_cti_i = 3'b111; wb_bte_i = '0;
    tbl_lock = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset:terms", 32'({wb_err_o, wb_rty_o, wb_ack_o}), 32'd0);
    check("reset:dat", wb_dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    wr("w12345", 20'h12345, 32'h8000_0ABC);
    rd("r12345", 20'h12345, 1'b0);
    rd("alias45", 20'h00045, 1'b0);
    rd("locked", 20'h12345, 1'b1);
    rd("unlocked", 20'h12345, 1'b0);

    xfer("hi_adr", 32'h0040_0000, 1'b1, 32'h8000_0555, 4'hf, 3'b111, 2'b00, 1'b0);
    rd("idx0", 20'h00000, 1'b0);
    xfer("bad_cti", adr_of(20'h12345), 1'b1, 32'h8000_0777, 4'hf, 3'b010, 2'b00, 1'b0);
    rd("after_cti", 20'h12345, 1'b0);

    // Write abandoned in WAIT: cyc drops right after acceptance.
    @(negedge clk);
    wb_adr_i = adr_of(20'h00777); wb_we_i = 1'b1; wb_dat_i = 32'h8000_1234;
    wb_sel_i = 4'hf; wb_cti_i = 3'b111; wb_bte_i = 2'b00;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    watch_terms(6, seen);
    check("abort:terms", 32'(seen), 32'd0);
    rd("abort:read", 20'h00777, 1'b0);

    wr("w00100", 20'h00100, 32'h8000_0042);
    rd("r00100", 20'h00100, 1'b0);

    // Reset in the middle of a read.
    @(negedge clk);
    wb_adr_i = adr_of(20'h00100); wb_we_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    watch_terms(6, seen);
    check("rst_mid:terms", 32'(seen), 32'd0);
    check("rst_mid:dat", wb_dat_o, 32'd0);
    model_clear();
    rd("rst:r12345", 20'h12345, 1'b0);
    rd("rst:r00100", 20'h00100, 1'b0);

    wr("w_set", 20'h0ABCD, 32'h83FF_FFFF);
    rd("r_set", 20'h0ABCD, 1'b0);
    wr("w_clr", 20'h0ABCD, 32'h0000_0000);
    rd("r_clr", 20'h0ABCD, 1'b0);

    for (int n = 0; n < 300; n++) begin
      vpn  = {14'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
      adr  = adr_of(vpn);
      if ($urandom_range(0, 19) == 0) adr = adr | (32'h1 << $urandom_range(22, 31));
      if ($urandom_range(0, 19) == 0) adr = adr | 32'($urandom_range(1, 3));
      we   = 1'($urandom_range(0, 1));
      dat  = $urandom;
      sel  = (we && $urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) :
             (we ? 4'hf : 4'($urandom));
      cti  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
      bte  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      lock = ($urandom_range(0, 7) == 0);
      xfer("rand", adr, we, dat, sel, cti, bte, lock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
